// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
//   fetch_state_e : controller FSM states
//   fetch_entry_t : prefetch buffer payload {pc, instr}
//   align_pc      : clears the byte-offset bits of a fetch address
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are word aligned.
  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO of fetch entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_flush     : synchronous clear; overrides push and pop
//   i_push      : write i_wdata at the tail (accepted if not full, or popping)
//   i_pop       : remove the head (ignored when empty)
//   o_full_c    : buffer holds DEPTH entries
//   o_empty_c   : buffer holds no entries
//   o_head_c    : head entry, all zeros when empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_wdata,
  input  logic         i_pop,
  output logic         o_full_c,
  output logic         o_empty_c,
  output fetch_entry_t o_head_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  fetch_entry_t r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop frees the slot in the same cycle, so a full buffer may still push.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_full_c  = w_full;
  assign o_empty_c = w_empty;
  assign o_head_c  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, addresses the combinational
// instruction memory, buffers {pc, instr} pairs and hands them to decode.
//   clk, rst_n     : clock, asynchronous active-low reset
//   fetch_en       : fetching permitted; low holds the PC while the buffer drains
//   imem_addr      : instruction memory address (the PC register)
//   imem_data      : word read from imem_addr in the same cycle
//   redirect_valid : taken branch/jump; flushes the buffer and reloads the PC
//   redirect_pc    : redirect target (byte offset ignored)
//   out_valid/out_ready/out_instr/out_pc : decode handshake on the buffer head
//   fetch_cnt      : words pushed into the buffer since reset (wrapping)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_cnt
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_cnt;

  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_wdata;
  fetch_entry_t w_head;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, push and pop decisions; redirect suppresses both transfers.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = !w_empty && out_ready && !redirect_valid;
    case (r_state)
      IDLE: begin
        if (fetch_en) w_state_nxt = FETCH;
      end
      FETCH: begin
        if (!fetch_en) begin
          w_state_nxt = IDLE;
        end else if (!redirect_valid && (!w_full || w_pop)) begin
          w_push = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // PC and push counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
    end else if (redirect_valid) begin
      r_pc <= align_pc(redirect_pc);
    end else if (w_push) begin
      r_pc        <= r_pc + INSTR_W'(PC_STEP);
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign w_wdata = {r_pc, imem_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (redirect_valid),
    .i_push    (w_push),
    .i_wdata   (w_wdata),
    .i_pop     (w_pop),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_head_c  (w_head)
  );

  assign imem_addr = r_pc;
  assign fetch_cnt = r_fetch_cnt;
  assign out_valid = !w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a main instance (RESET_PC=0) and a second
// instance (RESET_PC=FFFF_FFF8) for PC wrap. Memory returns addr^A5A5_0000.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr, imem_data, out_instr, out_pc, fetch_cnt;
  logic        out_valid;

  logic [31:0] w_imem_addr, w_imem_data, w_out_instr, w_out_pc, w_fetch_cnt;
  logic        w_out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  assign imem_data   = imem_addr   ^ 32'hA5A5_0000;
  assign w_imem_data = w_imem_addr ^ 32'hA5A5_0000;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fetch_cnt(fetch_cnt)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_pc(w_out_pc), .fetch_cnt(w_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".pc"},    out_pc,    exp_pc);
    chk({tag, ".instr"}, out_instr, exp_pc ^ 32'hA5A5_0000);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".instr"}, out_instr, 32'd0);
    chk({tag, ".pc"},    out_pc,    32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick(); tick();

    // Reset values
    chk_empty("rst");
    chk("rst.cnt",       fetch_cnt,   32'd0);
    chk("rst.addr",      imem_addr,   32'h0);
    chk("rst.wrap_addr", w_imem_addr, 32'hFFFF_FFF8);

    // Release with fetch enabled; cycle 0 is IDLE->FETCH with no push
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    tick();
    chk_empty("c0");
    chk("c0.cnt", fetch_cnt, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_head($sformatf("stream%0d", k), 32'(4 * (k - 1)));
      chk($sformatf("stream%0d.cnt", k),  fetch_cnt, 32'(k));
      chk($sformatf("stream%0d.addr", k), imem_addr, 32'(4 * k));
      chk($sformatf("wrap%0d.valid", k),  {31'd0, w_out_valid}, 32'd1);
      chk($sformatf("wrap%0d.pc", k),     w_out_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
    end

    // Backpressure: head C, fills to 2 entries, PC freezes at 0x14
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_head($sformatf("bp%0d", k), 32'h0C);
    end
    chk("bp.addr", imem_addr, 32'h14);
    chk("bp.cnt",  fetch_cnt, 32'd5);

    // Release: delivery continues 10, 14, 18 with no gap
    out_ready = 1'b1;
    tick(); chk_head("rel0", 32'h10);
    tick(); chk_head("rel1", 32'h14);
    tick(); chk_head("rel2", 32'h18);
    chk("rel.cnt",  fetch_cnt, 32'd8);
    chk("rel.addr", imem_addr, 32'h20);

    // Redirect while the buffer is full {18,1C}
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk_empty("redir.n1");
    chk("redir.addr", imem_addr, 32'h100);
    chk("redir.cnt",  fetch_cnt, 32'd8);
    tick(); chk_head("redir.n2", 32'h100);
    chk("redir.cnt2", fetch_cnt, 32'd9);
    tick(); chk_head("redir.n3", 32'h104);

    // fetch_en low for 3 cycles: buffer drains, PC holds at 0x108
    fetch_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fen%0d.valid", k), {31'd0, out_valid}, 32'd0);
      chk($sformatf("fen%0d.addr", k),  imem_addr, 32'h108);
    end
    chk("fen.cnt", fetch_cnt, 32'd10);
    fetch_en = 1'b1;
    tick(); chk("fen.idle2fetch", {31'd0, out_valid}, 32'd0);
    tick(); chk_head("fen.resume0", 32'h108);
    tick(); chk_head("fen.resume1", 32'h10C);
    chk("fen.cnt2", fetch_cnt, 32'd12);

    // Fill the buffer, then pulse reset asynchronously
    out_ready = 1'b0;
    tick(); chk_head("pre_rst", 32'h10C);
    chk("pre_rst.cnt", fetch_cnt, 32'd13);
    #2;
    rst_n = 1'b0;
    #1;
    chk_empty("arst");
    chk("arst.cnt",  fetch_cnt, 32'd0);
    chk("arst.addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick(); chk_empty("rst2.c0");
    tick(); chk_head("rst2.c1", 32'h0);
    chk("rst2.cnt", fetch_cnt, 32'd1);
    tick(); chk_head("rst2.c2", 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the combinational instruction memory (`inst_mem`). It owns the program counter, drives the memory address, captures each returned word together with its PC into a small prefetch buffer, and presents instructions to decode over a valid/ready handshake. It sits between `inst_mem` and the decode stage, and accepts control-flow redirects from execute.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `DEPTH`, 2, prefetch buffer entries (power of two, ≥2).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_en`  in  1  high = fetching permitted; low = hold PC, keep draining buffer.
- `imem_addr`  out  32  byte address to `inst_mem`; always equals the PC register.
- `imem_data`  in  32  word returned by `inst_mem` in the same cycle (combinational read).
- `redirect_valid`  in  1  branch/jump taken; flush and restart at `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] forced to 0.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction; 32'h0 when `out_valid`=0.
- `out_pc`  out  32  PC of head instruction; 32'h0 when `out_valid`=0.
- `fetch_cnt`  out  32  count of words pushed into the buffer since reset; wraps.

## Operation
- FSM states: IDLE, FETCH.
  - IDLE → FETCH when `fetch_en`=1.
  - FETCH → IDLE when `fetch_en`=0.
  - Redirect does not change state.
- Push: in FETCH, when no redirect is asserted, and the buffer is not full (or a pop happens in the same cycle), write {PC, `imem_data`} at the tail, set PC ← PC+4, and increment `fetch_cnt`.
- Pop: `out_valid` && `out_ready` removes the head.
- Simultaneous push and pop with the buffer full: both succeed, so occupancy is unchanged.
- Push and pop with the buffer empty: the pushed entry becomes the head next cycle. There is no bypass, so the buffer is never combinationally transparent.
- Redirect (highest priority, any state):
  - Buffer cleared and PC ← {`redirect_pc`[31:2], 2'b00}.
  - No push that cycle; any pop that cycle is discarded.
  - `fetch_cnt` is not incremented.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_instr` and `out_pc` hold. A redirect is the only event that may drop `out_valid` without a pop.
- `fetch_en`=0 in FETCH: the current cycle performs no push; the buffer continues to drain.

## Timing
- Reset values: state=IDLE, PC=`RESET_PC`, buffer empty, `out_valid`=0, `out_instr`=0, `out_pc`=0, `fetch_cnt`=0, `imem_addr`=`RESET_PC`.
- Reset asserted mid-operation clears everything immediately (asynchronous), including entries not yet consumed.
- With `fetch_en`=1 from reset release:
  - cycle 0: IDLE→FETCH, no push.
  - cycle 1: push of `RESET_PC`.
  - cycle 2: `out_valid`=1.
- Steady state with `out_ready`=1: one instruction per cycle, PCs consecutive by 4.
- Redirect latency: redirect at cycle n → `imem_addr`=target at n+1 → target at head with `out_valid`=1 at n+2. `out_valid`=0 at n+1.
- `out_ready` held low: the buffer fills to DEPTH entries, then PC freezes until a pop.

## Structure
- `fetch_pkg`: state enum (IDLE, FETCH), `INSTR_W`=32, `PC_STEP`=4, and a packed struct `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_fifo`: DEPTH-entry circular buffer with push/pop/flush. It uses read/write pointers with an extra wrap bit for full/empty, and a synchronous flush.
- `fetch_ctrl` holds the FSM, PC, counter and redirect priority logic.

## Test plan
- Reset release with `fetch_en`=1 and `out_ready`=1, memory returning addr^32'hA5A5_0000 → `out_pc` sequence 0,4,8,… one per cycle from cycle 2; `out_instr` matches; `fetch_cnt` tracks pushes.
- Backpressure: `out_ready`=0 for 6 cycles → exactly 2 entries buffered, `imem_addr` frozen at 8, head PC 0 stable. On release, PCs 0,4,8 are delivered without gap or duplicate.
- Redirect to 32'h0000_0103 while the buffer is full → `out_valid`=0 next cycle, `imem_addr`=32'h100, then head PC=32'h100 at n+2, with old entries never delivered.
- Wrap: `RESET_PC`=32'hFFFF_FFF8 → delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- `fetch_en` toggled low for 3 cycles mid-stream → buffer drains, `out_valid` goes to 0, and fetch resumes at the next sequential PC with no skipped PC.
- `rst_n` pulsed low mid-stream with entries buffered → `out_valid`=0 asynchronously, and fetch restarts at `RESET_PC` with `fetch_cnt`=0.
